fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end with a decoupling prefetch queue. It replaces the single-register fetch stage. It issues sequential requests to an instruction memory with a grant/valid handshake and arbitrary in-order response latency, and buffers returned words in a DEPTH-entry FIFO. It hands instructions and their next PC to decode under a ready/valid handshake, and squashes in-flight and queued work on a branch/jump redirect.

## Interface
- DATA_W, default 16: instruction width.
- ADDR_W, default 16: word-address width.
- DEPTH, default 4: queue entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect  in  1  taken branch/jump; squash everything and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request word address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid. One response per granted request, in order, latency of at least 1 cycle.
- imem_rdata  in  DATA_W  response instruction.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts (deasserted = stall).
- out_instr  out  DATA_W  head instruction.
- out_next_pc  out  ADDR_W  head instruction address + 1 (mod 2^ADDR_W).

## Operation
- State:
  - req_pc: next address to request.
  - rsp_pc: address of the next kept response.
  - FIFO of {next_pc, instr}: count, rd_ptr, wr_ptr.
  - outstanding: granted, not yet returned; width clog2(DEPTH)+1.
  - drop: responses still to be discarded.
- Reset values:
  - req_pc = rsp_pc = 0.
  - count = outstanding = drop = 0; FIFO pointers 0.
  - Outputs: imem_req = 0, out_valid = 0, out_instr = 0, out_next_pc = 0.
- Credit rule: imem_req = !redirect && (count + outstanding < DEPTH). imem_addr = req_pc. Pops in the same cycle do not add credit.
- Grant (imem_req && imem_gnt): req_pc += 1 with wrap, outstanding += 1.
- Response (imem_rvalid): outstanding -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise: push {rsp_pc+1, imem_rdata}, then rsp_pc += 1.
- Pop (out_valid && out_ready): rd_ptr += 1. Push and pop in the same cycle leave count unchanged.
- Overflow cannot occur because of the credit rule. Behaviour for an imem_rvalid with outstanding == 0 is undefined; the bench treats it as an error.
- Redirect cycle:
  - req_pc and rsp_pc are loaded with redirect_pc; FIFO is flushed (count = 0).
  - drop = outstanding + (grant this cycle, always 0) − (imem_rvalid this cycle), then outstanding = drop.
  - A response arriving in this cycle is discarded.
  - out_valid is forced 0; a same-cycle pop is ignored.
  - No request is issued this cycle; the first request at redirect_pc is issued the next cycle.
- Stall: while out_ready = 0, out_instr and out_next_pc hold.

## Timing
- Request-to-queue: the response edge writes the FIFO; out_valid rises the cycle after imem_rvalid.
- With gnt = 1 and latency L: first out_valid at cycle L+1 after reset release.
- Steady-state throughput is 1 instruction/cycle once DEPTH ≥ L+1.
- Redirect-to-first-instruction penalty = 1 + L + 1 cycles (bypass: 1 + L).
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests must not be delivered by the memory model.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count == 0 and a kept response arrives, out_valid = 1 in the same cycle, with out_instr = imem_rdata and out_next_pc = rsp_pc+1.
  - If out_ready = 1 that cycle, the word is consumed and not pushed.
- Undefined: all output comes from the FIFO head (registered path only).

## Test plan
- Reset release, gnt = 1, L = 1, ready = 1, mem[i] = 0x1000+i -> imem_addr 0,1,2,… on consecutive cycles; out_valid from cycle 2 with out_instr 0x1000, 0x1001, … and out_next_pc 1, 2, …, one per cycle.
- out_ready = 0 for 10 cycles, DEPTH = 4 -> at most 4 requests beyond the consumed point; imem_req drops; head holds 0x1000 / out_next_pc 1; no word is lost or duplicated on release.
- redirect with redirect_pc = 0x0040 and 2 requests outstanding (L = 3) -> those 2 responses are discarded; next imem_addr = 0x0040; first out_instr = mem[0x40] with out_next_pc 0x0041.
- imem_gnt toggling 1,0,1,0 -> imem_addr holds during the 0 cycles; output sequence stays contiguous.
- req_pc = 0xFFFF -> next address 0x0000; out_next_pc for mem[0xFFFF] = 0x0000.
- rst pulsed while queue is full -> outputs 0 the same cycle; restart fetch at address 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch front end's memory-side and decode-side
// handshakes plus the redirect request.
//
// Handshake rules, both directions:
//   Request side:  imem_req/imem_addr are offered by the fetch unit; a
//                  request transfers on any rising edge where imem_req and
//                  imem_gnt are both 1. imem_rvalid returns exactly one word
//                  per transferred request, in order, at least one cycle
//                  later; it carries no back-pressure.
//   Decode side:   out_valid/out_instr/out_next_pc are offered by the fetch
//                  unit; an instruction transfers on any rising edge where
//                  out_valid and out_ready are both 1. While out_ready is 0
//                  the offered instruction and next PC stay put.
//
// Modports:
//   master - the fetch unit (drives imem_req, imem_addr, out_*).
//   slave  - memory / decode / branch unit side.
interface fetch_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_next_pc;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_next_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_next_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch queue.
// Issues sequential word requests to instruction memory, buffers returned
// words with their next PC, and hands them to decode. A redirect squashes
// the queue and marks every in-flight response for discard.
//
// Parameters: DATA_W (instruction width), ADDR_W (word address width),
//             DEPTH (queue entries, power of two, >= 2).
// Ports:      clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - fetch_queue_if.master (memory, decode and redirect)
// Build option: FETCH_QUEUE_BYPASS_EN - when defined, a kept response that
//             arrives while the queue is empty is offered to decode in the
//             same cycle; otherwise all output comes from the queue head.
module fetch_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] reqPc;
    logic [ADDR_W-1:0] rspPc;
    logic [ADDR_W-1:0] rspNextPc;
    logic [DATA_W-1:0] fifoInstr  [DEPTH];
    logic [ADDR_W-1:0] fifoNextPc [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W:0]    used;
    logic              grant;
    logic              keep;
    logic              push;
    logic              fifoPop;
    logic              empty;

    // Every granted request reserves a queue slot until it is consumed or
    // discarded, so the queue can never overflow. Pops in this cycle do not
    // free a slot until the next cycle.
    assign used          = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req  = !rst && !bus.redirect && (used < (CNT_W+1)'(DEPTH));
    assign bus.imem_addr = reqPc;

    assign grant     = bus.imem_req && bus.imem_gnt;
    // A response is kept only if nothing stale is still ahead of it and no
    // redirect is squashing it in this very cycle.
    assign keep      = !rst && bus.imem_rvalid && (drop == '0) && !bus.redirect;
    assign rspNextPc = rspPc + ADDR_W'(1);
    assign empty     = (count == '0);
    assign fifoPop   = !rst && !bus.redirect && !empty && bus.out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass          = empty && keep;
    assign bus.out_valid   = !rst && !bus.redirect && (!empty || keep);
    assign bus.out_instr   = bypass ? bus.imem_rdata : fifoInstr[rdPtr];
    assign bus.out_next_pc = bypass ? rspNextPc : fifoNextPc[rdPtr];
    // A bypassed word consumed on arrival never enters the queue.
    assign push            = keep && !(bypass && bus.out_ready);
`else
    assign bus.out_valid   = !rst && !bus.redirect && !empty;
    assign bus.out_instr   = fifoInstr[rdPtr];
    assign bus.out_next_pc = fifoNextPc[rdPtr];
    assign push            = keep;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqPc       <= '0;
            rspPc       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifoInstr[i]  <= '0;
                fifoNextPc[i] <= '0;
            end
        end else if (bus.redirect) begin
            // No grant is possible this cycle; everything still in flight
            // after this edge becomes a response to throw away.
            reqPc       <= bus.redirect_pc;
            rspPc       <= bus.redirect_pc;
            count       <= '0;
            rdPtr       <= wrPtr;
            drop        <= outstanding - CNT_W'(bus.imem_rvalid);
            outstanding <= outstanding - CNT_W'(bus.imem_rvalid);
        end else begin
            if (grant) begin
                reqPc <= reqPc + ADDR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(bus.imem_rvalid);
            if (bus.imem_rvalid && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end
            if (keep) begin
                rspPc <= rspNextPc;
            end
            if (push) begin
                fifoInstr[wrPtr]  <= bus.imem_rdata;
                fifoNextPc[wrPtr] <= rspNextPc;
                wrPtr             <= wrPtr + PTR_W'(1);
            end
            if (fifoPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(fifoPop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue. An in-order memory
// model with per-request latency answers granted requests; the reference
// model is the program-order view: after reset or a redirect to P, decode
// must see P, P+1, ... and the memory must see requests P, P+1, ...;
// responses belonging to a squashed epoch never reach decode.
module tb_fetch_queue;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int nCmp = 0;
    int nFail = 0;
    int cyc;
    int latMin = 1;
    int latMax = 1;
    int epoch = 0;
    int lastDue;
    int firstValidCyc;
    int nGrants;
    int nPops;

    // memory model: requests granted but not yet answered
    logic [ADDR_W-1:0] pendAddr[$];
    int                pendDue[$];
    int                pendEpoch[$];
    // scoreboard: addresses of kept words waiting for decode, oldest first
    logic [ADDR_W-1:0] expQ[$];
    logic [ADDR_W-1:0] expReqPc;

    logic [ADDR_W-1:0] grantLog[$];
    logic [DATA_W-1:0] popInstrLog[$];
    logic [ADDR_W-1:0] popNpcLog[$];

    // last sampled outputs
    logic              sReq;
    logic [ADDR_W-1:0] sAddr;
    logic              sValid;
    logic [DATA_W-1:0] sInstr;
    logic [ADDR_W-1:0] sNpc;

    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        return 16'h1000 + a;
    endfunction

    task automatic resetAssert();
        rst = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.out_ready   = 1'b0;
        pendAddr.delete();
        pendDue.delete();
        pendEpoch.delete();
        expQ.delete();
        epoch++;
    endtask

    task automatic resetRelease();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        lastDue = -1;
        expReqPc = '0;
        firstValidCyc = -1;
        nGrants = 0;
        nPops = 0;
        grantLog.delete();
        popInstrLog.delete();
        popNpcLog.delete();
    endtask

    // One clock cycle: drive at posedge+1, sample and score at negedge.
    task automatic cycle(input bit gnt, input bit ready, input bit redir,
                         input logic [ADDR_W-1:0] rpc);
        bit dlv, kept, expReq, expValid, grant, pop;
        logic [ADDR_W-1:0] dlvAddr, head, headNext;
        int lat, due;
        dlv = (pendAddr.size() > 0) && (pendDue[0] <= cyc);
        dlvAddr = dlv ? pendAddr[0] : '0;
        bus.imem_gnt    = gnt;
        bus.out_ready   = ready;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.imem_rvalid = dlv;
        bus.imem_rdata  = dlv ? memWord(dlvAddr) : 16'($urandom);
        @(negedge clk);
        kept = 1'b0;
        if (dlv && !redir && (pendEpoch[0] == epoch)) kept = 1'b1;

        expReq = !redir && ((pendAddr.size() + expQ.size()) < DEPTH);
        nCmp++;
        if (bus.imem_req !== expReq) begin
            nFail++;
            $display("FAIL imem_req cyc=%0d: got %b expected %b", cyc, bus.imem_req, expReq);
        end
        if (bus.imem_req === 1'b1) begin
            nCmp++;
            if (bus.imem_addr !== expReqPc) begin
                nFail++;
                $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, bus.imem_addr, expReqPc);
            end
        end
        expValid = !redir && ((expQ.size() > 0) || (BYPASS && kept));
        nCmp++;
        if (bus.out_valid !== expValid) begin
            nFail++;
            $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, bus.out_valid, expValid);
        end
        if (expValid && (bus.out_valid === 1'b1)) begin
            head = (expQ.size() > 0) ? expQ[0] : dlvAddr;
            headNext = head + 16'd1;
            nCmp++;
            if ((bus.out_instr !== memWord(head)) || (bus.out_next_pc !== headNext)) begin
                nFail++;
                $display("FAIL head cyc=%0d: got instr %h npc %h expected instr %h npc %h",
                         cyc, bus.out_instr, bus.out_next_pc, memWord(head), headNext);
            end
        end
        sReq = bus.imem_req;
        sAddr = bus.imem_addr;
        sValid = bus.out_valid;
        sInstr = bus.out_instr;
        sNpc = bus.out_next_pc;
        if ((bus.out_valid === 1'b1) && (firstValidCyc < 0)) firstValidCyc = cyc;

        grant = (bus.imem_req === 1'b1) && gnt;
        pop = expValid && (bus.out_valid === 1'b1) && ready;
        if (dlv) begin
            void'(pendAddr.pop_front());
            void'(pendDue.pop_front());
            void'(pendEpoch.pop_front());
        end
        if (BYPASS && kept) expQ.push_back(dlvAddr);
        if (pop) begin
            nPops++;
            popInstrLog.push_back(bus.out_instr);
            popNpcLog.push_back(bus.out_next_pc);
            void'(expQ.pop_front());
        end
        if (!BYPASS && kept) expQ.push_back(dlvAddr);
        if (grant) begin
            nGrants++;
            grantLog.push_back(bus.imem_addr);
            lat = $urandom_range(latMax, latMin);
            due = cyc + lat;
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            pendAddr.push_back(bus.imem_addr);
            pendDue.push_back(due);
            pendEpoch.push_back(epoch);
            expReqPc = expReqPc + 16'd1;
        end
        if (redir) begin
            expQ.delete();
            epoch++;
            expReqPc = rpc;
            firstValidCyc = -1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        resetAssert();
        @(posedge clk);
        #1;
        nCmp++;
        if ((bus.imem_req !== 1'b0) || (bus.out_valid !== 1'b0) ||
            (bus.out_instr !== '0) || (bus.out_next_pc !== '0)) begin
            nFail++;
            $display("FAIL reset_outputs: got req %b valid %b instr %h npc %h expected 0 0 0000 0000",
                     bus.imem_req, bus.out_valid, bus.out_instr, bus.out_next_pc);
        end
        resetRelease();
        cycle(1'b0, 1'b1, 1'b0, '0);
        nCmp++;
        if ((sReq !== 1'b1) || (sAddr !== 16'h0000)) begin
            nFail++;
            $display("FAIL reset_first_req: got req %b addr %h expected 1 0000", sReq, sAddr);
        end
    endtask

    task automatic test_sequential();
        int expPops;
        resetAssert();
        latMin = 1;
        latMax = 1;
        resetRelease();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        nCmp++;
        if (firstValidCyc !== (BYPASS ? 1 : 2)) begin
            nFail++;
            $display("FAIL seq_first_valid: got cycle %0d expected %0d", firstValidCyc, BYPASS ? 1 : 2);
        end
        expPops = BYPASS ? 19 : 18;
        nCmp++;
        if (nPops !== expPops) begin
            nFail++;
            $display("FAIL seq_throughput: got %0d pops expected %0d", nPops, expPops);
        end
        nCmp++;
        if ((popInstrLog[0] !== 16'h1000) || (popNpcLog[0] !== 16'h0001) ||
            (popInstrLog[1] !== 16'h1001) || (popNpcLog[1] !== 16'h0002)) begin
            nFail++;
            $display("FAIL seq_first_words: got %h/%h %h/%h expected 1000/0001 1001/0002",
                     popInstrLog[0], popNpcLog[0], popInstrLog[1], popNpcLog[1]);
        end
    endtask

    task automatic test_stall();
        resetAssert();
        latMin = 1;
        latMax = 1;
        resetRelease();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        nCmp++;
        if ((nGrants !== DEPTH) || (sReq !== 1'b0)) begin
            nFail++;
            $display("FAIL stall_credit: got %0d grants req %b expected %0d grants req 0",
                     nGrants, sReq, DEPTH);
        end
        nCmp++;
        if ((sValid !== 1'b1) || (sInstr !== 16'h1000) || (sNpc !== 16'h0001)) begin
            nFail++;
            $display("FAIL stall_hold: got valid %b instr %h npc %h expected 1 1000 0001",
                     sValid, sInstr, sNpc);
        end
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        nCmp++;
        if ((popInstrLog[4] !== 16'h1004) || (popNpcLog[4] !== 16'h0005)) begin
            nFail++;
            $display("FAIL stall_release: got fifth %h/%h expected 1004/0005", popInstrLog[4], popNpcLog[4]);
        end
    endtask

    task automatic test_redirect();
        int rCyc, waitN, expGap;
        resetAssert();
        latMin = 3;
        latMax = 3;
        resetRelease();
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        rCyc = cyc;
        cycle(1'b1, 1'b1, 1'b1, 16'h0040);
        nPops = 0;
        popInstrLog.delete();
        popNpcLog.delete();
        cycle(1'b1, 1'b1, 1'b0, '0);
        nCmp++;
        if ((sReq !== 1'b1) || (sAddr !== 16'h0040)) begin
            nFail++;
            $display("FAIL redirect_addr: got req %b addr %h expected 1 0040", sReq, sAddr);
        end
        waitN = 0;
        while ((nPops == 0) && (waitN < 30)) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            waitN++;
        end
        nCmp++;
        if (nPops == 0) begin
            nFail++;
            $display("FAIL redirect_timeout: got no instruction in 30 cycles expected one");
        end else begin
            if ((popInstrLog[0] !== memWord(16'h0040)) || (popNpcLog[0] !== 16'h0041)) begin
                nFail++;
                $display("FAIL redirect_first: got %h/%h expected %h/0041",
                         popInstrLog[0], popNpcLog[0], memWord(16'h0040));
            end
        end
        expGap = BYPASS ? 4 : 5;
        nCmp++;
        if ((firstValidCyc - rCyc) !== expGap) begin
            nFail++;
            $display("FAIL redirect_penalty: got %0d cycles expected %0d", firstValidCyc - rCyc, expGap);
        end
    endtask

    task automatic test_gnt_toggle();
        logic [ADDR_W-1:0] held;
        bit haveHeld;
        resetAssert();
        latMin = 2;
        latMax = 2;
        resetRelease();
        haveHeld = 1'b0;
        held = '0;
        for (int i = 0; i < 16; i++) begin
            cycle((i % 2) == 0, 1'b1, 1'b0, '0);
            if (haveHeld && (sReq === 1'b1)) begin
                nCmp++;
                if (sAddr !== held) begin
                    nFail++;
                    $display("FAIL gnt_hold cyc=%0d: got addr %h expected %h", cyc - 1, sAddr, held);
                end
            end
            haveHeld = ((i % 2) == 1) && (sReq === 1'b1);
            held = sAddr;
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        nCmp++;
        if ((nPops !== nGrants) || (nPops < 4)) begin
            nFail++;
            $display("FAIL gnt_drain: got %0d pops for %0d grants expected equal and >= 4", nPops, nGrants);
        end
    endtask

    task automatic test_wrap();
        resetAssert();
        latMin = 1;
        latMax = 1;
        resetRelease();
        cycle(1'b1, 1'b1, 1'b1, 16'hFFFE);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        nCmp++;
        if ((grantLog[0] !== 16'hFFFE) || (grantLog[1] !== 16'hFFFF) || (grantLog[2] !== 16'h0000)) begin
            nFail++;
            $display("FAIL wrap_addr: got %h %h %h expected fffe ffff 0000", grantLog[0], grantLog[1], grantLog[2]);
        end
        nCmp++;
        if ((popInstrLog[1] !== memWord(16'hFFFF)) || (popNpcLog[1] !== 16'h0000)) begin
            nFail++;
            $display("FAIL wrap_npc: got %h/%h expected %h/0000", popInstrLog[1], popNpcLog[1], memWord(16'hFFFF));
        end
    endtask

    task automatic test_reset_full();
        resetAssert();
        latMin = 2;
        latMax = 2;
        resetRelease();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        nCmp++;
        if ((sValid !== 1'b1) || (nGrants !== DEPTH)) begin
            nFail++;
            $display("FAIL full_before_reset: got valid %b grants %0d expected 1 %0d", sValid, nGrants, DEPTH);
        end
        // reset lands mid-cycle, away from any clock edge
        bus.out_ready = 1'b1;
        bus.imem_gnt = 1'b1;
        #1;
        resetAssert();
        #1;
        nCmp++;
        if ((bus.imem_req !== 1'b0) || (bus.out_valid !== 1'b0) ||
            (bus.out_instr !== '0) || (bus.out_next_pc !== '0)) begin
            nFail++;
            $display("FAIL reset_async: got req %b valid %b instr %h npc %h expected 0 0 0000 0000",
                     bus.imem_req, bus.out_valid, bus.out_instr, bus.out_next_pc);
        end
        latMin = 1;
        latMax = 1;
        resetRelease();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        nCmp++;
        if ((grantLog[0] !== 16'h0000) || (popInstrLog[0] !== 16'h1000) || (popNpcLog[0] !== 16'h0001)) begin
            nFail++;
            $display("FAIL reset_restart: got addr %h first %h/%h expected 0000 1000/0001",
                     grantLog[0], popInstrLog[0], popNpcLog[0]);
        end
    endtask

    task automatic test_random();
        bit g, r, d;
        logic [ADDR_W-1:0] p;
        resetAssert();
        latMin = 1;
        latMax = 4;
        resetRelease();
        for (int i = 0; i < 1500; i++) begin
            g = ($urandom_range(3, 0) != 0);
            r = ($urandom_range(3, 0) != 0);
            d = ($urandom_range(39, 0) == 0);
            p = 16'($urandom);
            cycle(g, r, d, p);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        nCmp++;
        if (nPops < 200) begin
            nFail++;
            $display("FAIL random_progress: got %0d pops expected at least 200", nPops);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_gnt_toggle();
        test_wrap();
        test_reset_full();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
